// File: rtl/conv_dec_bin.sv
// Sequential BCD-to-binary converter: four BCD digits in, binary value out.
// Multiply-by-10-and-add over four cycles with start/busy/done handshake.
module conv_dec_bin #(
  parameter int ANCHO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       miles,
  input  logic [3:0]       centenas,
  input  logic [3:0]       decenas,
  input  logic [3:0]       unidades,
  output logic [ANCHO-1:0] numero,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic [13:0]       acc_q, acc_d;
  logic [1:0]        idx_q, idx_d;
  logic              flag_err_q, flag_err_d;
  logic [ANCHO-1:0]  numero_q, numero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              digits_bad;
  logic [3:0]        dig_cur;
  logic [13:0]       acc_x10;

  assign digits_bad = (miles    > 4'd9) |
                      (centenas > 4'd9) |
                      (decenas  > 4'd9) |
                      (unidades > 4'd9);

  assign dig_cur = dig_q[idx_q];

  // Wraps harmlessly for invalid digits; that result is discarded.
  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    flag_err_d = flag_err_q;
    numero_d   = numero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dig_d[0]   = miles;
          dig_d[1]   = centenas;
          dig_d[2]   = decenas;
          dig_d[3]   = unidades;
          flag_err_d = digits_bad;
          acc_d      = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        acc_d = acc_x10 + {10'd0, dig_cur};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = FIN;
        end
      end
      FIN: begin
        numero_d = flag_err_q ? '0 : ANCHO'(acc_q);
        error_d  = flag_err_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dig_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      flag_err_q <= 1'b0;
      numero_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      flag_err_q <= flag_err_d;
      numero_q   <= numero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign numero = numero_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule
